waves_nios_input_pio: RTL and testbench

WAVES_NIOS_INPUT_PIO -- requirements
Module: waves_nios_input_pio

---
 rtl/waves_nios_input_pio.sv | 161 ++++++++++++++++
 tb/tb_waves_nios_input_pio.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/waves_nios_input_pio.sv
// rtl/waves_nios_input_pio.sv - synchronized, debounced, edge-capturing input PIO with level interrupt
module waves_nios_input_pio #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;
    logic             unused_writedata;

    assign wr_en     = chipselect & ~write_n;
    assign wdata     = writedata[WIDTH-1:0];
    assign sync_last = sync_q[SYNC_STAGES-1];

    // Upper writedata bits are ignored when WIDTH < 32.
    assign unused_writedata = &{1'b0, writedata};

    // Metastability chain: in_port enters stage 0 and shifts toward the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign db = sync_last;
        end else begin : g_debounce
            localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

            logic [15:0]      cnt [WIDTH];
            logic [WIDTH-1:0] db_q;

            // Per-bit stability counter: a bit must differ from db for
            // DEBOUNCE_CYCLES consecutive cycles before db follows it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    db_q <= '0;
                    for (int b = 0; b < WIDTH; b++) begin
                        cnt[b] <= '0;
                    end
                end else begin
                    for (int b = 0; b < WIDTH; b++) begin
                        if (sync_last[b] != db_q[b]) begin
                            if (cnt[b] == CNT_LAST) begin
                                db_q[b] <= sync_last[b];
                                cnt[b]  <= '0;
                            end else begin
                                cnt[b]  <= cnt[b] + 16'd1;
                            end
                        end else begin
                            cnt[b] <= '0;
                        end
                    end
                end
            end

            assign db = db_q;
        end
    endgenerate

    // Previous debounced value, used as the reference for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_prev <= '0;
        end else begin
            db_prev <= db;
        end
    end

    // Edge selection: rising, falling, or either direction.
    always_comb begin
        edge_det = db & ~db_prev;
        if (EDGE_TYPE == 1) begin
            edge_det = ~db & db_prev;
        end else if (EDGE_TYPE == 2) begin
            edge_det = db ^ db_prev;
        end
    end

    // Write-1-to-clear mask for the edge capture register.
    always_comb begin
        clr_bits = '0;
        if (wr_en && (address == ADDR_EDGE)) begin
            clr_bits = wdata;
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask <= '0;
        end else if (wr_en && (address == ADDR_MASK)) begin
            irqmask <= wdata;
        end
    end

    // Sticky edge capture; a new edge beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~clr_bits) | edge_det;
        end
    end

    // Registered read mux, refreshed every cycle regardless of chipselect.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA: readdata <= 32'(db);
                ADDR_MASK: readdata <= 32'(irqmask);
                ADDR_EDGE: readdata <= 32'(edgecapture);
                default:   readdata <= '0;
            endcase
        end
    end

    // Level interrupt from the registered capture and mask values.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edgecapture & irqmask);
        end
    end

endmodule

// File: tb/tb_waves_nios_input_pio.sv
// tb/tb_waves_nios_input_pio.sv - self-checking bench for waves_nios_input_pio
module tb_waves_nios_input_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_bus;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    waves_nios_input_pio #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_bus[7:0]), .readdata(rd_a), .irq(irq_a));

    waves_nios_input_pio #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_bus[7:0]), .readdata(rd_b), .irq(irq_b));

    waves_nios_input_pio #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) dut_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_bus), .readdata(rd_c), .irq(irq_c));

    // Reference model: one entry per instance above.
    int P_W [3] = '{8, 8, 32};
    int P_S [3] = '{2, 3, 2};
    int P_N [3] = '{0, 4, 0};
    int P_E [3] = '{0, 2, 1};

    logic [31:0] m_samp   [3][4];
    logic [31:0] m_db     [3];
    logic [31:0] m_dbp    [3];
    logic [31:0] m_ec     [3];
    logic [31:0] m_mask   [3];
    logic [31:0] m_rd     [3];
    logic        m_irq    [3];
    int          m_streak [3][32];

    function automatic logic [31:0] width_mask(input int w);
        if (w >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] get_rd(input int i);
        if (i == 0) return rd_a;
        if (i == 1) return rd_b;
        return rd_c;
    endfunction

    function automatic logic get_irq(input int i);
        if (i == 0) return irq_a;
        if (i == 1) return irq_b;
        return irq_c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] wm, sync_last, db_now, edge_v, clr;
            logic        wr;
            wm = width_mask(P_W[i]);
            if (reset) begin
                m_db[i] = '0; m_dbp[i] = '0; m_ec[i] = '0; m_mask[i] = '0;
                m_rd[i] = '0; m_irq[i] = 1'b0;
                for (int s = 0; s < 4; s++) m_samp[i][s] = '0;
                for (int b = 0; b < 32; b++) m_streak[i][b] = 0;
            end else begin
                sync_last = m_samp[i][P_S[i]-1];
                db_now    = (P_N[i] == 0) ? sync_last : m_db[i];
                case (P_E[i])
                    0:       edge_v = db_now & ~m_dbp[i];
                    1:       edge_v = ~db_now & m_dbp[i];
                    default: edge_v = db_now ^ m_dbp[i];
                endcase
                wr  = chipselect && !write_n;
                clr = (wr && address == 2'd3) ? (writedata & wm) : 32'h0;
                case (address)
                    2'd0:    m_rd[i] = db_now;
                    2'd2:    m_rd[i] = m_mask[i];
                    2'd3:    m_rd[i] = m_ec[i];
                    default: m_rd[i] = 32'h0;
                endcase
                m_irq[i] = |(m_ec[i] & m_mask[i]);
                m_ec[i]  = (m_ec[i] & ~clr) | edge_v;
                if (wr && address == 2'd2) m_mask[i] = writedata & wm;
                if (P_N[i] > 0) begin
                    for (int b = 0; b < P_W[i]; b++) begin
                        if (sync_last[b] != m_db[i][b]) begin
                            m_streak[i][b]++;
                            if (m_streak[i][b] == P_N[i]) begin
                                m_db[i][b] = sync_last[b];
                                m_streak[i][b] = 0;
                            end
                        end else begin
                            m_streak[i][b] = 0;
                        end
                    end
                end
                m_dbp[i] = db_now;
                for (int s = 3; s > 0; s--) m_samp[i][s] = m_samp[i][s-1];
                m_samp[i][0] = in_bus & wm;
            end
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_rd[%0d]", i), get_rd(i), m_rd[i]);
            chk($sformatf("model_irq[%0d]", i), {31'd0, get_irq(i)}, {31'd0, m_irq[i]});
        end
    endtask

    // One clock: edge, model step, then sample DUT outputs on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_check();
    endtask

    task automatic idle(input logic [1:0] a);
        address = a; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] inp;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [17];

    initial begin
        tbl[0]  = '{2'd2, 1'b1, 1'b0, 32'hFFFF_FF3C, 32'h00, 32'h00, 1'b0};
        tbl[1]  = '{2'd2, 1'b0, 1'b1, 32'h0,         32'h00, 32'h3C, 1'b0};
        tbl[2]  = '{2'd1, 1'b1, 1'b0, 32'hFF,        32'h00, 32'h00, 1'b0};
        tbl[3]  = '{2'd1, 1'b0, 1'b1, 32'h0,         32'h00, 32'h00, 1'b0};
        tbl[4]  = '{2'd2, 1'b0, 1'b0, 32'h0,         32'h00, 32'h3C, 1'b0};
        tbl[5]  = '{2'd2, 1'b0, 1'b1, 32'h0,         32'h00, 32'h3C, 1'b0};
        tbl[6]  = '{2'd0, 1'b1, 1'b0, 32'h55,        32'h00, 32'h00, 1'b0};
        tbl[7]  = '{2'd0, 1'b0, 1'b1, 32'h0,         32'h00, 32'h00, 1'b0};
        tbl[8]  = '{2'd3, 1'b0, 1'b1, 32'h0,         32'h00, 32'h00, 1'b0};
        tbl[9]  = '{2'd0, 1'b0, 1'b1, 32'h0,         32'h0C, 32'h00, 1'b0};
        tbl[10] = '{2'd0, 1'b0, 1'b1, 32'h0,         32'h0C, 32'h00, 1'b0};
        tbl[11] = '{2'd0, 1'b0, 1'b1, 32'h0,         32'h0C, 32'h0C, 1'b0};
        tbl[12] = '{2'd3, 1'b0, 1'b1, 32'h0,         32'h0C, 32'h0C, 1'b1};
        tbl[13] = '{2'd3, 1'b1, 1'b0, 32'h04,        32'h0C, 32'h0C, 1'b1};
        tbl[14] = '{2'd3, 1'b0, 1'b1, 32'h0,         32'h0C, 32'h08, 1'b1};
        tbl[15] = '{2'd2, 1'b1, 1'b0, 32'h0,         32'h0C, 32'h3C, 1'b1};
        tbl[16] = '{2'd3, 1'b0, 1'b1, 32'h0,         32'h0C, 32'h08, 1'b0};

        reset = 1'b1; in_bus = 32'h0; idle(2'd0);
        @(negedge clk);
        run(3);
        chk("reset_rd_a", rd_a, 32'h0);   chk("reset_irq_a", {31'd0, irq_a}, 32'h0);
        chk("reset_rd_b", rd_b, 32'h0);   chk("reset_irq_b", {31'd0, irq_b}, 32'h0);
        chk("reset_rd_c", rd_c, 32'h0);   chk("reset_irq_c", {31'd0, irq_c}, 32'h0);
        reset = 1'b0;
        run(3);

        // Register map, data path latency, capture, clear and mask behaviour.
        for (int k = 0; k < 17; k++) begin
            address = tbl[k].addr; chipselect = tbl[k].cs; write_n = tbl[k].wn;
            writedata = tbl[k].wd; in_bus = tbl[k].inp;
            cyc();
            chk($sformatf("tbl%0d_rd", k), rd_a, tbl[k].exp_rd);
            chk($sformatf("tbl%0d_irq", k), {31'd0, irq_a}, {31'd0, tbl[k].exp_irq});
        end

        // Edge capture coinciding with its write-1-to-clear: set wins.
        wr_reg(2'd2, 32'h01); cyc();
        idle(2'd0); in_bus = 32'h0D; cyc();
        cyc();
        wr_reg(2'd3, 32'h01); cyc();
        idle(2'd3); cyc();
        chk("set_wins_ec", rd_a, 32'h09);
        chk("set_wins_irq", {31'd0, irq_a}, 32'h1);
        wr_reg(2'd3, 32'h01); cyc();
        chk("clear_irq_hold", {31'd0, irq_a}, 32'h1);
        idle(2'd3); cyc();
        chk("clear_ec", rd_a, 32'h08);
        chk("clear_irq_drop", {31'd0, irq_a}, 32'h0);

        // Debounce: a 3-cycle pulse is rejected, a held level is accepted.
        in_bus = 32'h0C; idle(2'd0); run(14);
        wr_reg(2'd3, 32'hFFFF_FFFF); cyc();
        idle(2'd0); in_bus = 32'h0D; run(3);
        in_bus = 32'h0C; run(10);
        chk("db_pulse_data", rd_b, 32'h0C);
        idle(2'd3); cyc();
        chk("db_pulse_ec", rd_b, 32'h00);
        idle(2'd0); in_bus = 32'h0D;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk($sformatf("db_hold%0d", k), rd_b, (k >= 7) ? 32'h0D : 32'h0C);
        end

        // Falling-only versus any-edge capture on bit 3.
        in_bus = 32'h05; run(12);
        wr_reg(2'd3, 32'hFFFF_FFFF); cyc();
        idle(2'd3); in_bus = 32'h0D; run(12);
        chk("fall_only_rise", rd_c, 32'h00);
        chk("any_rise", rd_b, 32'h08);
        wr_reg(2'd3, 32'hFFFF_FFFF); cyc();
        idle(2'd3); in_bus = 32'h05; run(12);
        chk("fall_only_fall", rd_c, 32'h08);
        chk("any_fall", rd_b, 32'h08);

        // Reset in the middle of a debounce count with irq asserted.
        wr_reg(2'd2, 32'hFFFF_FFFF); cyc();
        idle(2'd3); in_bus = 32'h07; run(6);
        chk("pre_reset_irq", {31'd0, irq_a}, 32'h1);
        reset = 1'b1; in_bus = 32'h0; wr_reg(2'd2, 32'hFF); cyc();
        chk("rst_rd_a", rd_a, 32'h0);  chk("rst_irq_a", {31'd0, irq_a}, 32'h0);
        chk("rst_rd_b", rd_b, 32'h0);  chk("rst_irq_b", {31'd0, irq_b}, 32'h0);
        chk("rst_rd_c", rd_c, 32'h0);  chk("rst_irq_c", {31'd0, irq_c}, 32'h0);
        reset = 1'b0; idle(2'd3); run(10);
        chk("post_rst_ec_a", rd_a, 32'h0);
        chk("post_rst_ec_b", rd_b, 32'h0);
        chk("post_rst_ec_c", rd_c, 32'h0);
        idle(2'd2); cyc();
        chk("post_rst_mask_a", rd_a, 32'h0);

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            reset      = ($urandom_range(0, 149) == 0);
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            if ($urandom_range(0, 5) == 0) begin
                in_bus = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                in_bus[$urandom_range(0, 31)] ^= 1'b1;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
